uart_resp_seq: RTL and testbench
================================

// Module: uart_resp_seq
// PURPOSE
//  Command/response sequencer between uart_rx and uart_tx. Latches each received command byte,
//  selects a fixed ASCII reply and feeds it to uart_tx one byte at a time under a busy handshake.
//  Replaces free-running divided-clock pacing with single-clock, handshake-driven sequencing.
// PARAMETERS
//  GAP_CYCLES  16  idle clk cycles inserted after each byte completes, before the next tx_start (0 = none)
//  MAX_LEN     8   max reply length in bytes; sizes the byte index counter
// PORTS
//  clk        in   1  system clock; all logic on posedge clk
//  rst_n      in   1  asynchronous active-low reset
//  rx_data    in   8  byte from uart_rx; qualified by rx_valid
//  rx_valid   in   1  1-cycle pulse: rx_data holds a new byte
//  tx_busy    in   1  high while uart_tx is shifting a frame
//  tx_data    out  8  byte presented to uart_tx; stable while tx_start=1 and while tx_busy=1
//  tx_start   out  1  level request; held until tx_busy is sampled high
//  seq_busy   out  1  high in every state except IDLE
//  overrun    out  1  sticky: a command arrived while not IDLE; cleared when a command is accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx 0, gap counter 0.
//  Command table: 0x31 '1' -> "CCNU" (43 43 4E 55); 0x32 '2' -> "PLAC" (50 4C 41 43);
//   any other byte -> "?" (3F), length 1.
//  FSM:
//   IDLE    : rx_valid=1 -> latch cmd, idx<=0, clear overrun, go REQ.
//   REQ     : tx_data=rom(cmd,idx), tx_start=1; tx_busy=1 sampled -> tx_start<=0, go SEND.
//   SEND    : wait tx_busy=0 -> last byte (idx==len-1) ? (GAP_CYCLES? GAP_LAST : IDLE)
//             : idx<=idx+1, (GAP_CYCLES? GAP : REQ).
//   GAP     : count GAP_CYCLES, then REQ.
//   GAP_LAST: count GAP_CYCLES, then IDLE.
//  Latency: tx_start rises 1 cycle after the rx_valid pulse is accepted in IDLE.
//  rx_valid in any non-IDLE state: byte dropped, overrun<=1. rx_valid in the cycle SEND/GAP_LAST
//   exits to IDLE is also dropped (accepted only while state==IDLE).
//  tx_busy already high on entry to REQ: treated as the ack (uart_tx stays level-driven).
//  idx never exceeds len-1; no wrap. Gap counter: $clog2(GAP_CYCLES+1) bits, saturates at terminal.
//  Reset mid-reply: immediate abort to IDLE, tx_start=0; the in-flight uart_tx frame is uart_tx's concern.
// CONFIGURATION
//  UART_RESP_CRLF_EN defined: every reply is followed by 0x0D 0x0A (len+2; "?" becomes 3F 0D 0A);
//   MAX_LEN must be >= 6.
//  Not defined: replies exactly as tabled; no terminator bytes.
// STRUCTURE
//  uart_pkg: state enum (IDLE,REQ,SEND,GAP,GAP_LAST), ASCII constants (CMD_1, CMD_2, CHAR_Q, CR, LF),
//   reply length constants.
//  Sub-module uart_resp_rom: combinational (cmd[7:0], idx) -> byte[7:0], len; holds the table and CRLF
//   extension; sequencer contains only FSM, counters and registers.
// TESTING
//  1. rx_valid with 0x31, tx model acks 2 cycles later, busy 100 cycles -> tx_data 43,43,4E,55; 4 starts;
//     seq_busy low after last gap.
//  2. 0x32 -> 50,4C,41,43; each consecutive tx_start edge separated by >= GAP_CYCLES after tx_busy falls.
//  3. 0x7A -> single 3F; with UART_RESP_CRLF_EN: 3F,0D,0A.
//  4. Second rx_valid (0x31) during byte 2 of reply -> reply unchanged, overrun=1;
//     next command in IDLE clears overrun.
//  5. tx_busy held high before REQ entry -> tx_start deasserts next cycle, sequence proceeds, no byte lost.
//  6. Assert rst_n low during SEND of byte 3 -> all outputs 0 next edge; new 0x31 restarts at 43.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_resp_seq command/response sequencer:
// FSM state encoding, command/reply ASCII constants and reply lengths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEND,
        GAP,
        GAP_LAST
    } state_t;

    localparam logic [7:0] CMD_1  = 8'h31;
    localparam logic [7:0] CMD_2  = 8'h32;
    localparam logic [7:0] CHAR_Q = 8'h3F;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;

    localparam logic [7:0] CHAR_C = 8'h43;
    localparam logic [7:0] CHAR_N = 8'h4E;
    localparam logic [7:0] CHAR_U = 8'h55;
    localparam logic [7:0] CHAR_P = 8'h50;
    localparam logic [7:0] CHAR_L = 8'h4C;
    localparam logic [7:0] CHAR_A = 8'h41;

    localparam int LEN_CMD  = 4;
    localparam int LEN_Q    = 1;
    localparam int LEN_TERM = 2;

    // Length of the tabled reply body, before any line terminator.
    function automatic int base_len(input logic [7:0] cmd);
        return (cmd == CMD_1 || cmd == CMD_2) ? LEN_CMD : LEN_Q;
    endfunction

endpackage

// File: rtl/uart_resp_rom.sv
// Combinational reply table: (cmd, idx) -> reply byte and total reply length.
// With UART_RESP_CRLF_EN defined every reply gets a trailing CR LF.
module uart_resp_rom
    import uart_pkg::*;
#(
    parameter int IW = 3,
    parameter int LW = 4
) (
    input  logic [7:0]    cmd,
    input  logic [IW-1:0] idx,
    output logic [7:0]    rom_byte,
    output logic [LW-1:0] len
);

    // Length depends on cmd only; kept apart from the byte lookup so the
    // sequencer can use it to compute the next index without a comb loop.
    always_comb begin
`ifdef UART_RESP_CRLF_EN
        len = LW'(base_len(cmd) + LEN_TERM);
`else
        len = LW'(base_len(cmd));
`endif
    end

    always_comb begin
        int ext;
        int blen;
        ext      = int'(idx);
        blen     = base_len(cmd);
        rom_byte = 8'h00;
        if (cmd == CMD_1) begin
            case (ext)
                0, 1:    rom_byte = CHAR_C;
                2:       rom_byte = CHAR_N;
                3:       rom_byte = CHAR_U;
                default: rom_byte = 8'h00;
            endcase
        end else if (cmd == CMD_2) begin
            case (ext)
                0:       rom_byte = CHAR_P;
                1:       rom_byte = CHAR_L;
                2:       rom_byte = CHAR_A;
                3:       rom_byte = CHAR_C;
                default: rom_byte = 8'h00;
            endcase
        end else if (ext == 0) begin
            rom_byte = CHAR_Q;
        end
`ifdef UART_RESP_CRLF_EN
        if (ext == blen) begin
            rom_byte = CR;
        end else if (ext == blen + 1) begin
            rom_byte = LF;
        end
`endif
    end

endmodule

// File: rtl/uart_resp_seq.sv
// Command/response sequencer between uart_rx and uart_tx; replies are paced
// by the tx_busy handshake plus GAP_CYCLES idle cycles. Option: UART_RESP_CRLF_EN.
module uart_resp_seq
    import uart_pkg::*;
#(
    parameter int GAP_CYCLES = 16,
    parameter int MAX_LEN    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       seq_busy,
    output logic       overrun
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_TERM = GW'(GAP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          overrun_q, overrun_d;
    logic          tx_start_q, tx_start_d;
    logic          seq_busy_q, seq_busy_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic [7:0]    rom_byte;
    logic [LW-1:0] len;
    logic          last;

    // The ROM is addressed with next-state cmd/idx so tx_data is registered
    // in the same edge that raises tx_start.
    uart_resp_rom #(.IW(IW), .LW(LW)) u_rom (
        .cmd      (cmd_d),
        .idx      (idx_d),
        .rom_byte (rom_byte),
        .len      (len)
    );

    assign cmd_d = (state_q == IDLE && rx_valid) ? rx_data : cmd_q;
    assign last  = (LW'(idx_q) == len - LW'(1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    idx_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (tx_busy) state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    if (last) begin
                        state_d = (GAP_CYCLES > 0) ? GAP_LAST : IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = (GAP_CYCLES > 0) ? GAP : REQ;
                    end
                end
            end
            GAP, GAP_LAST: begin
                if (gap_q == GAP_TERM) begin
                    gap_d   = '0;
                    state_d = (state_q == GAP) ? REQ : IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Commands are only taken in IDLE; anything else is flagged and dropped.
        if (rx_valid && state_q != IDLE) overrun_d = 1'b1;
    end

    assign tx_start_d = (state_d == REQ);
    assign seq_busy_d = (state_d != IDLE);
    assign tx_data_d  = (state_d == REQ) ? rom_byte : tx_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            overrun_q  <= 1'b0;
            tx_start_q <= 1'b0;
            seq_busy_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            overrun_q  <= overrun_d;
            tx_start_q <= tx_start_d;
            seq_busy_q <= seq_busy_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign seq_busy = seq_busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_resp_seq.sv
// Directed bench for uart_resp_seq with a simple uart_tx handshake model
// driven inline; expected bytes and gap timings are hand-derived constants.
module tb_uart_resp_seq;

    localparam int GAP = 16;
    // tx_start becomes visible GAP+1 negedges after tx_busy is dropped:
    // one edge for SEND to see busy low, then GAP cycles of gap.
    localparam int GAP_WAIT = GAP + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       seq_busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    uart_resp_seq #(.GAP_CYCLES(GAP), .MAX_LEN(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .seq_busy (seq_busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse a command; tx_start must be up one cycle later.
    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("accept_start", tx_start, 1'b1);
        chk("accept_busy", seq_busy, 1'b1);
    endtask

    // Model one uart_tx frame: ack 2 cycles after tx_start, busy for busy_len.
    task automatic serve(input logic [7:0] exp, input int busy_len, input int exp_wait,
                         input bit inject);
        int n;
        n = 0;
        while (!tx_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", tx_start, 1'b1);
        chk("start_wait", n, exp_wait);
        chk("tx_data", tx_data, exp);
        repeat (2) @(negedge clk);
        chk("start_held", tx_start, 1'b1);
        tx_busy = 1'b1;
        @(negedge clk);
        chk("start_drop", tx_start, 1'b0);
        if (inject) begin
            rx_data  = 8'h31;
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            chk("overrun_set", overrun, 1'b1);
            repeat (busy_len - 2) @(negedge clk);
        end else begin
            repeat (busy_len - 1) @(negedge clk);
        end
        chk("data_stable", tx_data, exp);
        tx_busy = 1'b0;
    endtask

    task automatic serve_term();
`ifdef UART_RESP_CRLF_EN
        serve(8'h0D, 20, GAP_WAIT, 1'b0);
        serve(8'h0A, 20, GAP_WAIT, 1'b0);
`endif
    endtask

    // After the last byte: seq_busy stays up through the trailing gap only.
    task automatic end_reply();
        repeat (GAP) @(negedge clk);
        chk("busy_in_gap", seq_busy, 1'b1);
        @(negedge clk);
        chk("busy_end", seq_busy, 1'b0);
        chk("no_extra_start", tx_start, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_seq_busy", seq_busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: "CCNU" with 100-cycle frames
        send_cmd(8'h31);
        serve(8'h43, 100, 0, 1'b0);
        serve(8'h43, 100, GAP_WAIT, 1'b0);
        serve(8'h4E, 100, GAP_WAIT, 1'b0);
        serve(8'h55, 100, GAP_WAIT, 1'b0);
        serve_term();
        end_reply();

        // 2: "PLAC", gap timing checked on every byte
        send_cmd(8'h32);
        serve(8'h50, 20, 0, 1'b0);
        serve(8'h4C, 20, GAP_WAIT, 1'b0);
        serve(8'h41, 20, GAP_WAIT, 1'b0);
        serve(8'h43, 20, GAP_WAIT, 1'b0);
        serve_term();
        end_reply();

        // 3: unknown command -> "?"
        send_cmd(8'h7A);
        serve(8'h3F, 20, 0, 1'b0);
        serve_term();
        end_reply();

        // 4: command during byte 2 is dropped and flagged
        send_cmd(8'h31);
        serve(8'h43, 20, 0, 1'b0);
        serve(8'h43, 20, GAP_WAIT, 1'b1);
        serve(8'h4E, 20, GAP_WAIT, 1'b0);
        serve(8'h55, 20, GAP_WAIT, 1'b0);
        serve_term();
        end_reply();
        chk("overrun_sticky", overrun, 1'b1);
        send_cmd(8'h7A);
        chk("overrun_clear", overrun, 1'b0);
        serve(8'h3F, 20, 0, 1'b0);
        serve_term();
        end_reply();

        // 5: tx_busy already high when REQ is entered
        tx_busy = 1'b1;
        send_cmd(8'h31);
        chk("early_data", tx_data, 8'h43);
        @(negedge clk);
        chk("early_ack_drop", tx_start, 1'b0);
        repeat (10) @(negedge clk);
        tx_busy = 1'b0;
        serve(8'h43, 20, GAP_WAIT, 1'b0);
        serve(8'h4E, 20, GAP_WAIT, 1'b0);
        serve(8'h55, 20, GAP_WAIT, 1'b0);
        serve_term();
        end_reply();

        // 6: reset during SEND of byte 3, then restart
        send_cmd(8'h31);
        serve(8'h43, 20, 0, 1'b0);
        serve(8'h43, 20, GAP_WAIT, 1'b0);
        begin
            int n;
            n = 0;
            while (!tx_start && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("b3_wait", n, GAP_WAIT);
            chk("b3_data", tx_data, 8'h4E);
        end
        tx_busy = 1'b1;
        @(negedge clk);
        chk("b3_send", tx_start, 1'b0);
        rx_data  = 8'h32;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("b3_overrun", overrun, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_tx_start", tx_start, 1'b0);
        chk("mid_rst_seq_busy", seq_busy, 1'b0);
        chk("mid_rst_overrun", overrun, 1'b0);
        @(negedge clk);
        tx_busy = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        send_cmd(8'h31);
        serve(8'h43, 20, 0, 1'b0);
        serve(8'h43, 20, GAP_WAIT, 1'b0);
        serve(8'h4E, 20, GAP_WAIT, 1'b0);
        serve(8'h55, 20, GAP_WAIT, 1'b0);
        serve_term();
        end_reply();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
